// File: rtl/serial_addsub.sv
// Chunk-serial add/subtract: processes a WIDTH-bit operand pair CHUNK bits per cycle, LSB first.
// States: IDLE | waiting for start ; RUN | one chunk per cycle, outputs load on the last chunk
module serial_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] y_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o,
   output logic             negative_o
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, y_q, y_d;
   logic             c_q, c_d, carry_q, carry_d, ovf_q, ovf_d;
   logic             zero_q, zero_d, neg_q, neg_d, done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [CHUNK:0]   chunk_sum;
   logic             cout, cin_msb;
   logic [WIDTH-1:0] res_shift;

   assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
   assign cout      = chunk_sum[CHUNK];
   // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
   assign cin_msb   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

   generate
      if (N == 1) begin : g_single
         assign res_shift = chunk_sum[CHUNK-1:0];
      end else begin : g_multi
         assign res_shift = {chunk_sum[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      y_d     = y_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = op_i ? ~b_i : b_i;
               c_d     = op_i;
               cnt_d   = CW'(N - 1);
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> CHUNK;
            b_d   = b_q >> CHUNK;
            c_d   = cout;
            res_d = res_shift;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               y_d     = res_shift;
               carry_d = cout;
               ovf_d   = cin_msb ^ cout;
               zero_d  = (res_shift == '0);
               neg_d   = res_shift[WIDTH-1];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign busy_o     = (state_q == RUN);
   assign done_o     = done_q;
   assign y_o        = y_q;
   assign carry_o    = carry_q;
   assign overflow_o = ovf_q;
   assign zero_o     = zero_q;
   assign negative_o = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (32/8, 16/16, 16/4) checked against a scoreboard.
module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;

   logic [35:0] sb0[$];
   logic [35:0] sb1[$];
   logic [35:0] sb2[$];

   logic        start0 = 0, op0 = 0, busy0, done0, c0, v0, z0, n0;
   logic [31:0] a0 = 0, b0 = 0, y0;
   logic        start1 = 0, op1 = 0, busy1, done1, c1, v1, z1, n1;
   logic [15:0] a1 = 0, b1 = 0, y1;
   logic        start2 = 0, op2 = 0, busy2, done2, c2, v2, z2, n2;
   logic [15:0] a2 = 0, b2 = 0, y2;

   serial_addsub #(.WIDTH(32), .CHUNK(8)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .op_i(op0), .a_i(a0), .b_i(b0),
      .busy_o(busy0), .done_o(done0), .y_o(y0), .carry_o(c0), .overflow_o(v0),
      .zero_o(z0), .negative_o(n0));

   serial_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .op_i(op1), .a_i(a1), .b_i(b1),
      .busy_o(busy1), .done_o(done1), .y_o(y1), .carry_o(c1), .overflow_o(v1),
      .zero_o(z1), .negative_o(n1));

   serial_addsub #(.WIDTH(16), .CHUNK(4)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .op_i(op2), .a_i(a2), .b_i(b2),
      .busy_o(busy2), .done_o(done2), .y_o(y2), .carry_o(c2), .overflow_o(v2),
      .zero_o(z2), .negative_o(n2));

   // Reference: {y, carry, overflow, zero, negative}; overflow from operand/result signs.
   function automatic logic [35:0] model(input int w, input logic op,
                                         input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, ua, ub, bb, s, yy;
      logic c, v, sa, sb, sy;
      mask = (64'd1 << w) - 64'd1;
      ua = {32'd0, a} & mask;
      ub = {32'd0, b} & mask;
      bb = op ? (~ub & mask) : ub;
      s  = ua + bb + {63'd0, op};
      yy = s & mask;
      c  = s[w];
      sa = ua[w-1];
      sb = ub[w-1];
      sy = yy[w-1];
      v  = op ? (sa != sb && sy != sa) : (sa == sb && sy != sa);
      return {yy[31:0], c, v, (yy == 0), sy};
   endfunction

   task automatic issue0(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [35:0] exp, output int t0);
      @(negedge clk);
      start0 = 1; op0 = op; a0 = a; b0 = b;
      sb0.push_back(exp);
      t0 = cyc + 1;
      @(negedge clk);
      start0 = 0; op0 = ~op; a0 = $urandom; b0 = $urandom;
   endtask

   task automatic wait_done0(output int tdone, output bit ok);
      ok = 0;
      tdone = cyc;
      for (int i = 0; i < 20; i++) begin
         if (done0) begin
            ok = 1;
            tdone = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy0, done0, y0, c0, v0, z0, n0} !== 38'd0) begin
         errors++;
         $display("FAIL reset_dut0: got busy=%b done=%b y=%h c=%b v=%b z=%b n=%b, want all 0",
                  busy0, done0, y0, c0, v0, z0, n0);
      end
      checks++;
      if ({busy1, done1, y1, c1, v1, z1, n1, busy2, done2, y2, c2, v2, z2, n2} !== 44'd0) begin
         errors++;
         $display("FAIL reset_dut12: got y1=%h y2=%h flags1=%b%b%b%b flags2=%b%b%b%b, want all 0",
                  y1, y2, c1, v1, z1, n1, c2, v2, z2, n2);
      end
      rst_n = 1;
   endtask

   task automatic test_directed();
      logic        ops [6] = '{0, 0, 0, 1, 1, 1};
      logic [31:0] as  [6] = '{32'h5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h0, 32'h8000_0000};
      logic [31:0] bs  [6] = '{32'h3, 32'h1, 32'h1, 32'h5, 32'h1, 32'h1};
      logic [35:0] ex  [6] = '{{32'h0000_0008, 4'b0000}, {32'h8000_0000, 4'b0101},
                               {32'h0000_0000, 4'b1010}, {32'h0000_0000, 4'b1010},
                               {32'hFFFF_FFFF, 4'b0001}, {32'h7FFF_FFFF, 4'b1100}};
      int t0, td;
      bit ok;
      logic [35:0] exp;
      for (int i = 0; i < 6; i++) begin
         issue0(ops[i], as[i], bs[i], ex[i], t0);
         wait_done0(td, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL directed_timeout[%0d]: no done within 20 cycles", i);
            void'(sb0.pop_front());
            continue;
         end
         exp = sb0.pop_front();
         checks++;
         if ({y0, c0, v0, z0, n0} !== exp) begin
            errors++;
            $display("FAIL directed_result[%0d]: got y=%h cvzn=%b%b%b%b, want y=%h cvzn=%b",
                     i, y0, c0, v0, z0, n0, exp[35:4], exp[3:0]);
         end
         checks++;
         if (td - t0 != 4) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d, want 4", i, td - t0);
         end
         @(negedge clk);
         checks++;
         if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL directed_pulse[%0d]: got done=%b busy=%b, want 0 0", i, done0, busy0);
         end
      end
   endtask

   task automatic test_ignored_start();
      int t0, td;
      bit ok;
      logic [35:0] exp;
      logic [31:0] prev_y;
      prev_y = y0;
      issue0(0, 32'd1000, 32'd234, model(32, 0, 32'd1000, 32'd234), t0);
      start0 = 1; op0 = 1; a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678;
      checks++;
      if (busy0 !== 1'b1 || y0 !== prev_y) begin
         errors++;
         $display("FAIL ignored_run_state: got busy=%b y=%h, want busy=1 y=%h", busy0, y0, prev_y);
      end
      @(negedge clk);
      start0 = 0;
      wait_done0(td, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ignored_timeout: no done within 20 cycles");
      end
      exp = sb0.pop_front();
      checks++;
      if ({y0, c0, v0, z0, n0} !== exp) begin
         errors++;
         $display("FAIL ignored_result: got y=%h cvzn=%b%b%b%b, want y=%h cvzn=%b",
                  y0, c0, v0, z0, n0, exp[35:4], exp[3:0]);
      end
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL ignored_no_queue: got busy=%b, want 0", busy0);
      end
   endtask

   task automatic test_back_to_back();
      int t0, td;
      bit ok;
      logic [35:0] exp;
      issue0(1, 32'h0001_0000, 32'h0000_0001, model(32, 1, 32'h0001_0000, 32'h0000_0001), t0);
      wait_done0(td, ok);
      exp = sb0.pop_front();
      checks++;
      if (!ok || {y0, c0, v0, z0, n0} !== exp) begin
         errors++;
         $display("FAIL b2b_first: got ok=%b y=%h cvzn=%b%b%b%b, want y=%h cvzn=%b",
                  ok, y0, c0, v0, z0, n0, exp[35:4], exp[3:0]);
      end
      start0 = 1; op0 = 0; a0 = 32'h89AB_CDEF; b0 = 32'h7654_3211;
      sb0.push_back(model(32, 0, 32'h89AB_CDEF, 32'h7654_3211));
      t0 = cyc + 1;
      @(negedge clk);
      start0 = 0; a0 = 0; b0 = 0;
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b1 || y0 !== exp[35:4]) begin
         errors++;
         $display("FAIL b2b_accept: got done=%b busy=%b y=%h, want 0 1 %h", done0, busy0, y0, exp[35:4]);
      end
      wait_done0(td, ok);
      exp = sb0.pop_front();
      checks++;
      if (!ok || {y0, c0, v0, z0, n0} !== exp) begin
         errors++;
         $display("FAIL b2b_second: got ok=%b y=%h cvzn=%b%b%b%b, want y=%h cvzn=%b",
                  ok, y0, c0, v0, z0, n0, exp[35:4], exp[3:0]);
      end
      checks++;
      if (td - t0 != 4) begin
         errors++;
         $display("FAIL b2b_latency: got %0d, want 4", td - t0);
      end
   endtask

   task automatic test_reset_abort();
      int t0, td;
      bit ok, saw_done;
      logic [35:0] exp;
      issue0(0, 32'h1111_1111, 32'h2222_2222, model(32, 0, 32'h1111_1111, 32'h2222_2222), t0);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({busy0, done0, y0, c0, v0, z0, n0} !== 38'd0) begin
         errors++;
         $display("FAIL abort_async_clear: got busy=%b done=%b y=%h cvzn=%b%b%b%b, want all 0",
                  busy0, done0, y0, c0, v0, z0, n0);
      end
      void'(sb0.pop_back());
      saw_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done0 !== 1'b0) saw_done = 1;
      end
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         if (done0 !== 1'b0) saw_done = 1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_no_done: got a done pulse, want none");
      end
      issue0(1, 32'h0000_0010, 32'h0000_0020, model(32, 1, 32'h0000_0010, 32'h0000_0020), t0);
      wait_done0(td, ok);
      exp = sb0.pop_front();
      checks++;
      if (!ok || {y0, c0, v0, z0, n0} !== exp || td - t0 != 4) begin
         errors++;
         $display("FAIL abort_restart: got ok=%b y=%h cvzn=%b%b%b%b lat=%0d, want y=%h cvzn=%b lat=4",
                  ok, y0, c0, v0, z0, n0, td - t0, exp[35:4], exp[3:0]);
      end
   endtask

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_sweep();
      int t0;
      bit got1, got2;
      logic [35:0] exp;
      for (int it = 0; it < 1000; it++) begin
         @(negedge clk);
         start1 = 1; op1 = 1'($urandom); a1 = pick16(); b1 = pick16();
         start2 = 1; op2 = 1'($urandom); a2 = pick16(); b2 = pick16();
         sb1.push_back(model(16, op1, {16'd0, a1}, {16'd0, b1}));
         sb2.push_back(model(16, op2, {16'd0, a2}, {16'd0, b2}));
         t0 = cyc + 1;
         got1 = 0;
         got2 = 0;
         for (int i = 0; i < 12 && !(got1 && got2); i++) begin
            @(negedge clk);
            if (i == 0) begin
               start1 = 0; start2 = 0;
               a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
            end
            if (done1 && !got1) begin
               got1 = 1;
               exp = sb1.pop_front();
               checks++;
               if ({16'd0, y1, c1, v1, z1, n1} !== exp || cyc - t0 != 1) begin
                  errors++;
                  $display("FAIL sweep_n1[%0d]: got y=%h cvzn=%b%b%b%b lat=%0d, want y=%h cvzn=%b lat=1",
                           it, y1, c1, v1, z1, n1, cyc - t0, exp[19:4], exp[3:0]);
               end
            end
            if (done2 && !got2) begin
               got2 = 1;
               exp = sb2.pop_front();
               checks++;
               if ({16'd0, y2, c2, v2, z2, n2} !== exp || cyc - t0 != 4) begin
                  errors++;
                  $display("FAIL sweep_n4[%0d]: got y=%h cvzn=%b%b%b%b lat=%0d, want y=%h cvzn=%b lat=4",
                           it, y2, c2, v2, z2, n2, cyc - t0, exp[19:4], exp[3:0]);
               end
            end
         end
         if (!got1 || !got2) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout[%0d]: got done1=%b done2=%b, want both", it, got1, got2);
            sb1.delete();
            sb2.delete();
         end
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_ignored_start();
      test_back_to_back();
      test_reset_abort();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
